// File: rtl/sr_scan_ctrl.sv
// Row-scanned 4x8 LED driver: double-buffered pixel memory serialised into a 74595,
// with latch/output-enable sequencing and a one-hot row drive.
module sr_scan_ctrl #(
  parameter int HALF       = 2,
  parameter int HOLD_TICKS = 64
) (
  input  logic       clk_16mhz,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       swap_req,
  output logic       swap_done,
  output logic       sr_clk,
  output logic       sr_ser,
  output logic       sr_lat,
  output logic       sr_oe_n,
  output logic [3:0] line,
  output logic       frame_start
);

  localparam int DW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int TW = $clog2(2 * HOLD_TICKS + 16) + 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(HALF - 1);
  localparam logic [TW-1:0] SHIFT_LAST = TW'(15);
  localparam logic [TW-1:0] LATCH_LAST = TW'(1);
  localparam logic [TW-1:0] HOLD_LAST  = TW'(2 * HOLD_TICKS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, HOLD} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] div_cnt;
  logic [TW-1:0] tcnt;
  logic          tick;
  logic          hold_exit;
  logic          armed;
  logic          pending;
  logic          swap_take;
  logic          do_copy;
  logic          wr_fire;
  logic [1:0]    row;
  logic [7:0]    word;
  logic [7:0]    front    [4];
  logic [7:0]    back     [4];
  logic [7:0]    back_nxt [4];

  // Tick divider is held at zero in IDLE and LOAD so every SHIFT starts phase-aligned.
  assign tick = (state != IDLE) && (state != LOAD) && (div_cnt == DIV_LAST);

  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (state == IDLE || state == LOAD || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Tick count within the current state: 16 ticks of SHIFT, 2 of LATCH, 2*HOLD_TICKS of HOLD.
  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (state_nxt != state || state == IDLE || state == LOAD) begin
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_exit = 1'b0;
    case (state)
      IDLE:    if (enable && armed) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (tick && tcnt == SHIFT_LAST) state_nxt = LATCH;
      LATCH:   if (tick && tcnt == LATCH_LAST) state_nxt = HOLD;
      HOLD: begin
        if (tick && tcnt == HOLD_LAST) begin
          hold_exit = 1'b1;
          state_nxt = enable ? LOAD : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sr_lat      = (state == LATCH);
  assign sr_oe_n     = (state != HOLD);
  assign frame_start = (state == LOAD) && (row == 2'd0);
  assign sr_ser      = word[7];
  assign wr_ready    = !pending;

  // armed keeps the first LOAD off the first edge after reset release.
  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      armed  <= 1'b0;
      row    <= '0;
      word   <= '0;
      sr_clk <= 1'b0;
      line   <= '0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      if (state == IDLE) begin
        row <= '0;
      end else if (hold_exit) begin
        row <= row + 1'b1;
      end
      // The word shifts on the falling tick, so sr_ser only moves while sr_clk is low.
      if (state == LOAD) begin
        word <= front[row];
      end else if (state == SHIFT && tick && sr_clk) begin
        word <= {word[6:0], 1'b0};
      end
      if (state == SHIFT && tick) begin
        sr_clk <= ~sr_clk;
      end else if (state != SHIFT) begin
        sr_clk <= 1'b0;
      end
      if (state == LATCH && state_nxt == HOLD) begin
        line <= 4'b0001 << row;
      end else if (hold_exit && !enable) begin
        line <= '0;
      end
    end
  end

  assign wr_fire   = wr_valid && wr_ready;
  assign swap_take = swap_req && !pending;
  // The copy source includes a same-cycle write, so a write landing with swap_req is not lost.
  assign do_copy   = (pending || swap_take) &&
                     ((state == IDLE) || (hold_exit && row == 2'd3));

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      back_nxt[i] = back[i];
    end
    if (wr_fire) begin
      back_nxt[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      swap_done <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        front[i] <= '0;
        back[i]  <= '0;
      end
    end else begin
      swap_done <= do_copy;
      if (do_copy) begin
        pending <= 1'b0;
      end else if (swap_take) begin
        pending <= 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        back[i] <= back_nxt[i];
        if (do_copy) begin
          front[i] <= back_nxt[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_sr_scan_ctrl.sv
// Bench for sr_scan_ctrl: directed scenarios plus random traffic, every cycle compared
// against a row-timeline reference model.
module tb_sr_scan_ctrl;
  localparam int HALF       = 2;
  localparam int HOLD_TICKS = 4;
  localparam int T_LAT      = 1 + 16 * HALF;
  localparam int T_HOLD     = T_LAT + 2 * HALF;
  localparam int ROWLEN     = T_HOLD + 2 * HALF * HOLD_TICKS;
  localparam int FRAME      = 4 * ROWLEN;
  localparam int FRAME_EXP  = 4 * (1 + 4 * 8 + 4 + 16);

  logic       clk_16mhz = 1'b0;
  logic       rst_n     = 1'b0;
  logic       enable    = 1'b0;
  logic       wr_valid  = 1'b0;
  logic [1:0] wr_addr   = '0;
  logic [7:0] wr_data   = '0;
  logic       swap_req  = 1'b0;
  logic       wr_ready, swap_done, sr_clk, sr_ser, sr_lat, sr_oe_n, frame_start;
  logic [3:0] line;

  sr_scan_ctrl #(.HALF(HALF), .HOLD_TICKS(HOLD_TICKS)) dut (
    .clk_16mhz(clk_16mhz), .rst_n(rst_n), .enable(enable),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .swap_done(swap_done),
    .sr_clk(sr_clk), .sr_ser(sr_ser), .sr_lat(sr_lat), .sr_oe_n(sr_oe_n),
    .line(line), .frame_start(frame_start)
  );

  always #5 clk_16mhz = ~clk_16mhz;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: whether a scan is running, which row, and the cycle offset inside it.
  bit         m_run, m_pend, m_done, m_armed;
  int         m_row, m_t;
  logic [7:0] m_front [4];
  logic [7:0] m_back  [4];
  logic [3:0] m_line;

  // Observation state.
  logic [7:0] shreg;
  int         nbits, cyc, fs_last, fs_gap, oe_low, hold_len, done_count, last_rise, clk_gap;
  logic [7:0] cap [4];
  logic [3:0] lseq [$];
  logic       prev_clk, prev_ser;
  logic [3:0] prev_line;

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_done = 0; m_armed = 0;
    m_row = 0; m_t = 0; m_line = '0;
    for (int i = 0; i < 4; i++) begin
      m_front[i] = '0;
      m_back[i]  = '0;
    end
    nbits = 0;
  endtask

  task automatic model_update(input logic en, input logic wv, input logic [1:0] wa,
                              input logic [7:0] wd, input logic sq);
    logic [7:0] bn [4];
    bit take, hexit, copy;
    for (int i = 0; i < 4; i++) bn[i] = m_back[i];
    if (wv && !m_pend) bn[wa] = wd;
    take  = sq && !m_pend;
    hexit = m_run && (m_t == ROWLEN - 1);
    copy  = (m_pend || take) && (!m_run || (hexit && m_row == 3));
    m_done = copy;
    if (copy) begin
      for (int i = 0; i < 4; i++) m_front[i] = bn[i];
      m_pend = 0;
    end else if (take) begin
      m_pend = 1;
    end
    for (int i = 0; i < 4; i++) m_back[i] = bn[i];
    if (m_run && m_t == T_HOLD - 1) m_line = 4'(1 << m_row);
    if (hexit && !en) m_line = '0;
    if (!m_run) begin
      if (en && m_armed) begin
        m_run = 1; m_row = 0; m_t = 0;
      end
    end else if (hexit) begin
      if (en) begin
        m_row = (m_row + 1) % 4; m_t = 0;
      end else begin
        m_run = 0;
      end
    end else begin
      m_t++;
    end
    m_armed = 1;
  endtask

  // {sr_clk, sr_ser, sr_lat, sr_oe_n, line, frame_start, wr_ready, swap_done}
  function automatic logic [10:0] exp_outs();
    logic c, s, l, o, f;
    int k, tk, fl;
    c = 0; s = 0; l = 0; o = 1; f = 0;
    if (m_run) begin
      if (m_t >= 1 && m_t < T_LAT) begin
        k  = m_t - 1;
        tk = k / HALF;
        c  = ((tk % 2) == 1);
        fl = tk / 2;
        if (fl < 8) s = m_front[m_row][7 - fl];
      end
      l = (m_t >= T_LAT && m_t < T_HOLD);
      o = (m_t < T_HOLD);
      f = (m_t == 0 && m_row == 0);
    end
    return {c, s, l, o, m_line, f, !m_pend, m_done};
  endfunction

  function automatic int onehot_idx(input logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      default: return 3;
    endcase
  endfunction

  task automatic step();
    logic en, wv, sq;
    logic [1:0] wa;
    logic [7:0] wd;
    en = enable; wv = wr_valid; wa = wr_addr; wd = wr_data; sq = swap_req;
    @(posedge clk_16mhz);
    if (rst_n) model_update(en, wv, wa, wd, sq);
    else model_reset();
    #1;
    cyc++;
    check("outs", 32'({sr_clk, sr_ser, sr_lat, sr_oe_n, line, frame_start, wr_ready, swap_done}),
          32'(exp_outs()));
    check("lat_oe_excl", 32'(sr_lat && !sr_oe_n), 32'd0);
    check("ser_stable", 32'(sr_clk && (sr_ser !== prev_ser)), 32'd0);
    if (sr_clk && !prev_clk) begin
      shreg = {shreg[6:0], sr_ser};
      nbits++;
      if (last_rise >= 0 && (cyc - last_rise) < 10) clk_gap = cyc - last_rise;
      last_rise = cyc;
    end
    if (line != prev_line && line != 4'b0000) begin
      check("nbits", 32'(nbits), 32'd8);
      cap[onehot_idx(line)] = shreg;
      nbits = 0;
      lseq.push_back(line);
    end
    if (frame_start) begin
      if (fs_last >= 0) fs_gap = cyc - fs_last;
      fs_last = cyc;
    end
    if (!sr_oe_n) oe_low++;
    else if (oe_low > 0) begin
      hold_len = oe_low;
      oe_low = 0;
    end
    if (swap_done) done_count++;
    prev_clk = sr_clk; prev_ser = sr_ser; prev_line = line;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] pat0 [4];
    logic [7:0] pat1 [4];
    bit found;
    int first;
    pat0[0] = 8'h81; pat0[1] = 8'h42; pat0[2] = 8'h24; pat0[3] = 8'h18;
    for (int i = 0; i < 4; i++) pat1[i] = 8'($urandom_range(1, 255));
    model_reset();
    shreg = '0; cyc = 0; fs_last = -1; fs_gap = 0; oe_low = 0; hold_len = 0;
    done_count = 0; last_rise = -1; clk_gap = 0;
    prev_clk = 0; prev_ser = 0; prev_line = '0;
    for (int i = 0; i < 4; i++) cap[i] = 8'hFF;

    // Reset state
    repeat (3) step();
    check("rst_outs", 32'({sr_clk, sr_ser, sr_lat, sr_oe_n, line, frame_start, wr_ready, swap_done}),
          32'(11'b0_0_0_1_0000_0_1_0));

    // Load pattern, swap together with the last write, start scanning
    rst_n = 1'b1;
    step();
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_addr = 2'(i);
      wr_data = pat0[i];
      if (i == 3) begin
        swap_req = 1'b1;
        enable   = 1'b1;
      end
      step();
    end
    wr_valid = 1'b0; swap_req = 1'b0;
    check("swap_done_idle", 32'(swap_done), 32'd1);
    lseq.delete();
    repeat (2 * FRAME + 5) step();
    for (int i = 0; i < 4; i++) check("frame0_row", 32'(cap[i]), 32'(pat0[i]));
    check("line_seq0", 32'(lseq[0]), 32'(4'b0001));
    check("line_seq1", 32'(lseq[1]), 32'(4'b0010));
    check("frame_period", 32'(fs_gap), 32'(FRAME_EXP));
    check("hold_len", 32'(hold_len), 32'd16);
    check("sr_clk_period", 32'(clk_gap), 32'd4);

    // New back data, swap requested in row 1 HOLD, repeat swap and a blocked write ignored
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_addr = 2'(i);
      wr_data = pat1[i];
      step();
    end
    wr_valid = 1'b0;
    found = 0;
    for (int n = 0; n < 2 * FRAME && !found; n++) begin
      step();
      if (line == 4'b0010 && !sr_oe_n) found = 1;
    end
    check("wait_row1_hold", 32'(found), 32'd1);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    done_count = 0;
    check("rdy_pending", 32'(wr_ready), 32'd0);
    repeat (5) step();
    wr_valid = 1'b1; wr_addr = 2'd0; wr_data = ~pat1[0];
    step();
    wr_valid = 1'b0; swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    found = 0;
    for (int n = 0; n < 3 * ROWLEN && !found; n++) begin
      step();
      if (swap_done) found = 1;
    end
    check("wait_swap_done", 32'(found), 32'd1);
    check("swap_at_row3_exit", 32'(line), 32'(4'b1000));
    check("rdy_after_swap", 32'(wr_ready), 32'd1);
    repeat (FRAME + 5) step();
    for (int i = 0; i < 4; i++) check("frame1_row", 32'(cap[i]), 32'(pat1[i]));
    check("single_swap", 32'(done_count), 32'd1);

    // Enable dropped mid-SHIFT of row 2
    found = 0;
    for (int n = 0; n < 2 * FRAME && !found; n++) begin
      step();
      if (line == 4'b0010 && sr_clk) found = 1;
    end
    check("wait_row2_shift", 32'(found), 32'd1);
    cap[2] = 8'h00;
    repeat (3) step();
    enable = 1'b0;
    repeat (ROWLEN + 10) step();
    check("row2_completed", 32'(cap[2]), 32'(pat1[2]));
    check("idle_outs", 32'({sr_clk, sr_oe_n, line}), 32'(6'b0_1_0000));

    // Random traffic
    enable = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_addr  = 2'($urandom_range(0, 3));
      wr_data  = 8'($urandom_range(0, 255));
      swap_req = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 499) == 0) enable = ~enable;
      step();
    end
    wr_valid = 1'b0; swap_req = 1'b0; enable = 1'b1;

    // Asynchronous reset during HOLD, then restart blank
    found = 0;
    for (int n = 0; n < 2 * FRAME && !found; n++) begin
      step();
      if (!sr_oe_n) found = 1;
    end
    check("wait_hold", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_outs", 32'({sr_clk, sr_ser, sr_lat, sr_oe_n, line, frame_start, wr_ready, swap_done}),
          32'(11'b0_0_0_1_0000_0_1_0));
    model_reset();
    repeat (2) step();
    for (int i = 0; i < 4; i++) cap[i] = 8'hFF;
    rst_n = 1'b1;
    first = 0;
    for (int n = 1; n <= 5; n++) begin
      step();
      if (frame_start && first == 0) first = n;
    end
    check("first_load_edge", 32'(first), 32'd2);
    repeat (FRAME + 5) step();
    for (int i = 0; i < 4; i++) check("blank_row", 32'(cap[i]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
